// File: rtl/core_pkg.sv
// core_pkg: shared encodings for the branch resolution / prediction path.
//   - PC_sel encodings (pcsel_e)
//   - RV32I opcode and branch funct3 constants
//   - br_eval(): actual outcome of a B-type from the ALU compare flags
//   - ctr_next(): 2-bit saturating counter step
package core_pkg;

  typedef enum logic [2:0] {
    PCSEL_SEQ     = 3'b000,
    PCSEL_BR      = 3'b001,
    PCSEL_JAL     = 3'b010,
    PCSEL_JALR    = 3'b011,
    PCSEL_RECOVER = 3'b100
  } pcsel_e;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic legal;  // funct3 names a real branch
    logic taken;  // actual outcome; 0 for illegal encodings
  } br_res_t;

  function automatic br_res_t br_eval(input logic [2:0] f3, input logic eq,
                                      input logic lt, input logic ltu);
    br_res_t r;
    r.legal = 1'b1;
    r.taken = 1'b0;
    case (f3)
      F3_BEQ:  r.taken = eq;
      F3_BNE:  r.taken = !eq;
      F3_BLT:  r.taken = lt;
      F3_BGE:  r.taken = !lt;
      F3_BLTU: r.taken = ltu;
      F3_BGEU: r.taken = !ltu;
      default: r.legal = 1'b0;  // 010/011: resolve as not-taken
    endcase
    return r;
  endfunction

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] n;
    n = ctr;
    if (taken && ctr != 2'b11)       n = ctr + 2'd1;
    else if (!taken && ctr != 2'b00) n = ctr - 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/branch_predict_unit_bht.sv
// bht_table: array of 2-bit saturating counters.
// Present only when BRANCH_PREDICT_EN is defined.
//   clk, rst      : core clock, synchronous active-high reset (all -> CTR_INIT)
//   i_rd_idx      : lookup index; o_rd_ctr is combinational (pre-update value)
//   i_upd_en      : apply a saturating step at i_upd_idx on the next edge
//   i_upd_taken   : step direction (1 = toward 11, 0 = toward 00)
`ifdef BRANCH_PREDICT_EN
module bht_table
  import core_pkg::*;
#(
  parameter int         DEPTH    = 64,
  parameter int         IDX_W    = $clog2(DEPTH),
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_rd_ctr,
  input  logic             i_upd_en,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken
);

  logic [1:0] r_ctr [DEPTH];

  // Read straight from the array: a same-cycle update is not yet visible.
  assign o_rd_ctr = r_ctr[i_rd_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_ctr[i] <= CTR_INIT;
    end else if (i_upd_en) begin
      r_ctr[i_upd_idx] <= ctr_next(r_ctr[i_upd_idx], i_upd_taken);
    end
  end

endmodule
`endif

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: resolves JAL/JALR/B-type in EX, drives PC_sel/flush,
// and supplies fetch with a 2-bit-counter taken prediction.
// Build option: BRANCH_PREDICT_EN. Undefined -> no table, pred_taken=0,
// every taken branch redirects and counts as a misprediction.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   if_pc, if_is_branch   : fetch lookup -> pred_taken (combinational)
//   ex_valid, ex_opcode, ex_funct3, ex_pc, ex_pred_taken,
//   ex_eq, ex_lt, ex_ltu  : EX-stage instruction and compare flags
//   PC_sel, flush         : PC mux select and IF/ID kill (combinational)
//   br_cnt, mispred_cnt   : saturating event counters (registered)
module branch_predict_unit
  import core_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CTR_INIT  = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_is_branch,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic            ex_eq,
  input  logic            ex_lt,
  input  logic            ex_ltu,
  output logic [2:0]      PC_sel,
  output logic            flush,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  br_res_t     w_res;
  logic        w_pred;      // prediction the resolution logic compares against
  logic        w_upd;       // legal, valid branch resolving this cycle
  logic        w_mispred;
  pcsel_e      w_sel;
  logic        w_flush;
  logic [31:0] r_br_cnt;
  logic [31:0] r_mispred_cnt;
  logic        w_unused;

`ifdef BRANCH_PREDICT_EN
  logic [1:0] w_rd_ctr;

  bht_table #(
    .DEPTH    (BHT_DEPTH),
    .IDX_W    (IDX_W),
    .CTR_INIT (CTR_INIT)
  ) u_bht (
    .clk         (clk),
    .rst         (rst),
    .i_rd_idx    (if_pc[IDX_W+1:2]),
    .o_rd_ctr    (w_rd_ctr),
    .i_upd_en    (w_upd),
    .i_upd_idx   (ex_pc[IDX_W+1:2]),
    .i_upd_taken (w_res.taken)
  );

  assign pred_taken = !rst && if_is_branch && w_rd_ctr[1];
  assign w_pred     = ex_pred_taken;
  assign w_unused   = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0],
                        ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};
`else
  // Static not-taken: the carried prediction is ignored so a stale
  // ex_pred_taken can never trigger a recovery.
  assign pred_taken = 1'b0;
  assign w_pred     = 1'b0;
  assign w_unused   = ^{if_pc, if_is_branch, ex_pc, ex_pred_taken};
`endif

  assign w_res     = br_eval(ex_funct3, ex_eq, ex_lt, ex_ltu);
  assign w_mispred = w_res.taken != w_pred;

  always_comb begin
    w_sel   = PCSEL_SEQ;
    w_flush = 1'b0;
    w_upd   = 1'b0;
    if (!rst && ex_valid) begin
      case (ex_opcode)
        OP_JAL: begin
          w_sel   = PCSEL_JAL;
          w_flush = 1'b1;
        end
        OP_JALR: begin
          if (ex_funct3 == 3'b000) begin
            w_sel   = PCSEL_JALR;
            w_flush = 1'b1;
          end
        end
        OP_BRANCH: begin
          w_upd = w_res.legal;
          // Illegal funct3 has taken=0, so only a predicted-taken one redirects.
          if (w_res.taken && !w_pred) begin
            w_sel   = PCSEL_BR;
            w_flush = 1'b1;
          end else if (!w_res.taken && w_pred) begin
            w_sel   = PCSEL_RECOVER;
            w_flush = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign PC_sel = w_sel;
  assign flush  = w_flush;

  // w_upd is already low during reset, so reset always wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else if (w_upd) begin
      if (r_br_cnt != 32'hFFFF_FFFF) r_br_cnt <= r_br_cnt + 32'd1;
      if (w_mispred && r_mispred_cnt != 32'hFFFF_FFFF)
        r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign br_cnt      = r_br_cnt;
  assign mispred_cnt = r_mispred_cnt;

endmodule
